carry_look_ahead_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 12 +
 rtl/cla_block4.sv | 33 +++
 rtl/carry_look_ahead_adder.sv | 89 ++++++++
 tb/tb_carry_look_ahead_adder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and types for the carry-look-ahead adder.
package cla_pkg;

  localparam int unsigned CLA_BLOCK_W = 4;

  // Group generate/propagate pair produced by each 4-bit block.
  typedef struct packed {
    logic g;
    logic p;
  } cla_pg_t;

endpackage

// File: rtl/cla_block4.sv
// Combinational 4-bit look-ahead block: sum bits plus group generate/propagate.
module cla_block4
  import cla_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output cla_pg_t    pg
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = a & b;
  assign p = a ^ b;

  // Expanded carry equations, each a flat sum of products from c0.
  assign c1 = g[0] | (p[0] & c0);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c0);

  assign s = p ^ {c3, c2, c1, c0};

  assign pg.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
  assign pg.p = &p;

endmodule

// File: rtl/carry_look_ahead_adder.sv
// Registered two-level carry-look-ahead adder: sum/cout one clock after a, b, cin.
// Define CLA_GROUP_PG_EN to add registered whole-word grp_g/grp_p outputs.
module carry_look_ahead_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_GROUP_PG_EN
  output logic             grp_g,
  output logic             grp_p,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NBLK = WIDTH / CLA_BLOCK_W;

  if (WIDTH == 0 || (WIDTH % CLA_BLOCK_W) != 0) begin : g_bad_width
    $error("carry_look_ahead_adder: WIDTH must be a positive multiple of 4");
  end

  logic [NBLK-1:0]  blk_c;
  cla_pg_t          blk_pg [NBLK];
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    cla_block4 u_blk (
      .a  (a[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .b  (b[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .c0 (blk_c[k]),
      .s  (sum_c[k*CLA_BLOCK_W +: CLA_BLOCK_W]),
      .pg (blk_pg[k])
    );
  end

  // Top-level look-ahead: block carry-ins from group terms and cin.
  always_comb begin
    logic c;
    blk_c = '0;
    c     = cin;
    for (int unsigned k = 0; k < NBLK; k++) begin
      blk_c[k] = c;
      c        = blk_pg[k].g | (blk_pg[k].p & c);
    end
    cout_c = c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= sum_c;
      cout <= cout_c;
    end
  end

`ifdef CLA_GROUP_PG_EN
  logic word_g_c;
  logic word_p_c;

  // Whole-word group terms, independent of cin, for a higher look-ahead level.
  always_comb begin
    word_g_c = 1'b0;
    word_p_c = 1'b1;
    for (int unsigned k = 0; k < NBLK; k++) begin
      word_g_c = blk_pg[k].g | (blk_pg[k].p & word_g_c);
      word_p_c = word_p_c & blk_pg[k].p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_g <= 1'b0;
      grp_p <= 1'b0;
    end else begin
      grp_g <= word_g_c;
      grp_p <= word_p_c;
    end
  end
`endif

endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Scoreboard bench for carry_look_ahead_adder at WIDTH=4 and WIDTH=16.
module tb_carry_look_ahead_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a4, b4;
  logic        cin4;
  logic [15:0] a16, b16;
  logic        cin16;
  logic [3:0]  sum4;
  logic        cout4;
  logic [15:0] sum16;
  logic        cout16;
`ifdef CLA_GROUP_PG_EN
  logic        grp_g4, grp_p4, grp_g16, grp_p16;
`endif

  typedef struct {
    logic [3:0]  s4;
    logic        c4;
    logic        g4;
    logic        p4;
    logic [15:0] s16;
    logic        c16;
    logic        g16;
    logic        p16;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  carry_look_ahead_adder #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .a    (a4),
    .b    (b4),
    .cin  (cin4),
`ifdef CLA_GROUP_PG_EN
    .grp_g(grp_g4),
    .grp_p(grp_p4),
`endif
    .sum  (sum4),
    .cout (cout4)
  );

  carry_look_ahead_adder #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .a    (a16),
    .b    (b16),
    .cin  (cin16),
`ifdef CLA_GROUP_PG_EN
    .grp_g(grp_g16),
    .grp_p(grp_p16),
`endif
    .sum  (sum16),
    .cout (cout16)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector on the falling edge and record what the next rising edge must produce.
  task automatic drive(input logic [3:0] a4_i, input logic [3:0] b4_i, input logic c4_i,
                       input logic [15:0] a16_i, input logic [15:0] b16_i, input logic c16_i);
    exp_t        e;
    logic [4:0]  r4;
    logic [16:0] r16;
    @(negedge clk);
    a4 = a4_i;  b4 = b4_i;  cin4 = c4_i;
    a16 = a16_i; b16 = b16_i; cin16 = c16_i;
    r4    = 5'(a4_i) + 5'(b4_i) + 5'(c4_i);
    r16   = 17'(a16_i) + 17'(b16_i) + 17'(c16_i);
    e.s4  = r4[3:0];
    e.c4  = r4[4];
    e.s16 = r16[15:0];
    e.c16 = r16[16];
    // Group generate: word carries out on its own; group propagate: every bit differs.
    r4    = 5'(a4_i) + 5'(b4_i);
    r16   = 17'(a16_i) + 17'(b16_i);
    e.g4  = r4[4];
    e.g16 = r16[16];
    e.p4  = ((a4_i ^ b4_i) == 4'hF);
    e.p16 = ((a16_i ^ b16_i) == 16'hFFFF);
    q.push_back(e);
  endtask

  task automatic drive_rand();
    drive(4'($urandom), 4'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sum4"}, 32'(sum4), 32'd0);
    chk({tag, "_cout4"}, 32'(cout4), 32'd0);
    chk({tag, "_sum16"}, 32'(sum16), 32'd0);
    chk({tag, "_cout16"}, 32'(cout16), 32'd0);
`ifdef CLA_GROUP_PG_EN
    chk({tag, "_grp4"}, 32'({grp_g4, grp_p4}), 32'd0);
    chk({tag, "_grp16"}, 32'({grp_g16, grp_p16}), 32'd0);
`endif
  endtask

  // Monitor: every capture edge out of reset with a pending expectation is checked.
  always begin
    exp_t e;
    @(posedge clk);
    if (!rst && q.size() > 0) begin
      #1;
      e = q.pop_front();
      chk("sum4", 32'(sum4), 32'(e.s4));
      chk("cout4", 32'(cout4), 32'(e.c4));
      chk("sum16", 32'(sum16), 32'(e.s16));
      chk("cout16", 32'(cout16), 32'(e.c16));
`ifdef CLA_GROUP_PG_EN
      chk("grp_g4", 32'(grp_g4), 32'(e.g4));
      chk("grp_p4", 32'(grp_p4), 32'(e.p4));
      chk("grp_g16", 32'(grp_g16), 32'(e.g16));
      chk("grp_p16", 32'(grp_p16), 32'(e.p16));
`endif
    end
  end

  initial begin
    rst = 1'b1;
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    #3;
    chk_zero("reset_init");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=4 vectors; 16-bit lane gets its own corner cases alongside.
    drive(4'b0101, 4'b1100, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
    drive(4'b1101, 4'b0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(4'b1001, 4'b1100, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    drive(4'b1111, 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(4'b1111, 4'b0000, 1'b1, 16'h8000, 16'h8000, 1'b0);
    drive(4'b1111, 4'b1111, 1'b1, 16'h0F0F, 16'hF0F0, 1'b1);
    drive(4'b0000, 4'b0000, 1'b0, 16'h1234, 16'h4321, 1'b0);

    // Back-to-back random vectors.
    for (int i = 0; i < 16; i++) drive_rand();

    // Asynchronous reset mid-stream drops the pending result.
    drive_rand();
    #2;
    rst = 1'b1;
    #1;
    chk_zero("reset_async");
    q.delete();
    @(posedge clk);
    #1;
    chk_zero("reset_edge");
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1010, 4'b0110, 1'b1, 16'hAAAA, 16'h5555, 1'b1);

    for (int i = 0; i < 200; i++) drive_rand();

    for (int i = 0; i < 8 && q.size() > 0; i++) @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
